// File: rtl/s1_sched_pkg.sv
// -----------------------------------------------------------------------------
// s1_sched_pkg
//   Shared types and constants for the S1 slice scheduler.
//   - state_t    : scheduler FSM states (IDLE, RESP)
//   - NREQ       : number of requesters sharing the slice
//   - ID_W       : requester ID width
//   - CTL_W      : per-requester control width {A1,B1,A0}
//   - sel_decode : maps {A1,B1,A0} to the 2-bit slice select {A1|B1, A0}
// -----------------------------------------------------------------------------
package s1_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CTL_W = 3;
  localparam int SEL_W = 2;

  // S1-cell select: S1 = A1 | B1, S0 = A0. A0 is deliberately not gated by
  // reset here, so selects 01/11 are reachable during normal operation.
  function automatic logic [SEL_W-1:0] sel_decode(input logic [CTL_W-1:0] ctl);
    return {ctl[2] | ctl[1], ctl[0]};
  endfunction

endpackage

// File: rtl/s1_slice_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//   Combinational 4-way round-robin arbiter. Searches req starting at ptr and
//   wrapping modulo 4; grants the first valid requester found.
//   Ports:
//     req    in  [3:0]  request vector
//     ptr    in  [1:0]  highest-priority requester index
//     en     in  1      arbitration enable; no grant when low
//     gnt    out [3:0]  one-hot grant (all zero when no grant)
//     gnt_id out [1:0]  index of granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter4
  import s1_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  always_comb begin : arb
    logic            found;
    logic [ID_W-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Index arithmetic wraps naturally at ID_W bits (mod 4).
      idx = ptr + ID_W'(k);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s1_slice_scheduler.sv
// -----------------------------------------------------------------------------
// s1_slice_scheduler
//   Shares one registered 4:1 mux slice among 4 requesters. Round-robin
//   arbitration, 1-cycle issue->result latency, result tagged with requester
//   ID, and a wrapping count of accepted responses.
//
//   Handshake: a transfer happens on a rising CLK edge when valid and ready are
//   both high in the preceding cycle. On the request side, request i transfers
//   when req_valid[i] & req_ready[i]; req_ready is a one-hot grant and never has
//   more than one bit set. On the response side, the result transfers when
//   rsp_valid & rsp_ready; while rsp_valid is high and rsp_ready is low,
//   rsp_data/rsp_id/rsp_valid are held and no new request is granted.
//
//   Ports:
//     CLK            in   1      clock, rising edge
//     CLR            in   1      asynchronous active-high reset
//     req_valid      in   4      per-requester request valid
//     req_ready      out  4      one-hot grant
//     req_ctl        in   12     {A1,B1,A0} for requester i at [3i+2:3i]
//     d00..d11       in   N      shared slice operands
//     rsp_valid      out  1      result valid
//     rsp_ready      in   1      consumer accepts result
//     rsp_data       out  N      registered slice output
//     rsp_id         out  2      owner of rsp_data
//     busy           out  1      high in RESP state
//     done_cnt       out  CNT_W  accepted responses (wraps)
//     dbg_state_o    out  1      FSM state (IDLE=0, RESP=1)
//     dbg_rr_ptr_o   out  2      current round-robin pointer
// -----------------------------------------------------------------------------
module s1_slice_scheduler
  import s1_sched_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CTL_W-1:0] req_ctl,
  input  logic [N-1:0]          d00,
  input  logic [N-1:0]          d01,
  input  logic [N-1:0]          d10,
  input  logic [N-1:0]          d11,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_cnt,
  output logic                  dbg_state_o,
  output logic [ID_W-1:0]       dbg_rr_ptr_o
);

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;
  logic [N-1:0]    rsp_data_q;
  logic [N-1:0]    rsp_data_d;
  logic [ID_W-1:0] rsp_id_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic [CNT_W-1:0] done_cnt_d;

  logic             can_issue;
  logic             arb_en;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             accept;
  logic             rsp_fire;
  logic [CTL_W-1:0] ctl_g;
  logic [SEL_W-1:0] sel;

  // A new request may issue when the slice register is free or is being
  // drained this same cycle (back-to-back throughput of one per cycle).
  assign can_issue = (state_q == IDLE) || rsp_ready;
  // Grants are suppressed while reset is asserted.
  assign arb_en    = can_issue && !CLR;
  assign rsp_fire  = (state_q == RESP) && rsp_ready;

  rr_arbiter4 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept = |gnt;

  // Operand select for the granted requester; operands sampled this cycle only.
  assign ctl_g = req_ctl[gnt_id*CTL_W +: CTL_W];
  assign sel   = sel_decode(ctl_g);

  always_comb begin
    rsp_data_d = d00;
    unique case (sel)
      2'b00:   rsp_data_d = d00;
      2'b01:   rsp_data_d = d01;
      2'b10:   rsp_data_d = d10;
      2'b11:   rsp_data_d = d11;
      default: rsp_data_d = d00;
    endcase
  end

  assign rr_ptr_d   = gnt_id + ID_W'(1);
  assign done_cnt_d = done_cnt_q + CNT_W'(1);

  // Scheduler FSM with its registered outputs. A pending response at reset is
  // dropped and not counted.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      if (rsp_fire) begin
        done_cnt_q <= done_cnt_d;
      end
      if (accept) begin
        rsp_data_q <= rsp_data_d;
        rsp_id_q   <= gnt_id;
        rr_ptr_q   <= rr_ptr_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready && !accept) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = gnt;
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign done_cnt     = done_cnt_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_s1_slice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_s1_slice_scheduler
//   Directed bench for s1_slice_scheduler. A second instance with CNT_W=4
//   shares all inputs so the counter wrap can be observed alongside the
//   default-width counter.
// -----------------------------------------------------------------------------
module tb_s1_slice_scheduler;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0]  req_valid = '0;
  logic [11:0] req_ctl   = '0;
  logic [N-1:0] d00 = '0, d01 = '0, d10 = '0, d11 = '0;
  logic        rsp_ready = 1'b0;

  logic [3:0]   req_ready, req_ready4;
  logic         rsp_valid, rsp_valid4;
  logic [N-1:0] rsp_data, rsp_data4;
  logic [1:0]   rsp_id, rsp_id4;
  logic         busy, busy4;
  logic [15:0]  done_cnt;
  logic [3:0]   done_cnt4;
  logic         dbg_state, dbg_state4;
  logic [1:0]   dbg_rr_ptr, dbg_rr_ptr4;

  s1_slice_scheduler #(.N(N), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctl(req_ctl), .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .done_cnt(done_cnt),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  s1_slice_scheduler #(.N(N), .CNT_W(4)) dut4 (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready4),
    .req_ctl(req_ctl), .d00(d00), .d01(d01), .d10(d10), .d11(d11),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
    .rsp_id(rsp_id4), .busy(busy4), .done_cnt(done_cnt4),
    .dbg_state_o(dbg_state4), .dbg_rr_ptr_o(dbg_rr_ptr4)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];
  logic [1:0]   exp_id_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N-1:0] e_data;
    logic [1:0]   e_id;

    // Reset from power-up
    #1 CLR = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_done_cnt",  32'(done_cnt),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rr_ptr",    32'(dbg_rr_ptr), 32'd0);
    req_valid = 4'hF;
    settle();
    chk("rst_req_ready_gated", 32'(req_ready), 32'd0);
    req_valid = 4'h0;
    tick();
    tick();
    CLR = 1'b0;

    // Single request: requester 1, ctl {A1,B1,A0}={0,1,1} -> sel 11 -> d11
    d00 = 8'h11; d01 = 8'h22; d10 = 8'h33; d11 = 8'h44;
    req_ctl   = 12'b000_000_011_000;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    settle();
    chk("single_req_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;   // requester 3 waits behind the pending result
    settle();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data",  32'(rsp_data),  32'h44);
    chk("single_rsp_id",    32'(rsp_id),    32'd1);
    chk("single_busy",      32'(busy),      32'd1);

    // Backpressure: three stalled cycles, outputs held, no grant
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_data",  32'(rsp_data),  32'h44);
      chk("bp_rsp_id",    32'(rsp_id),    32'd1);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      settle();
    end
    chk("bp_done_held", 32'(done_cnt), 32'd0);
    rsp_ready = 1'b1;
    settle();
    // rr_ptr=2: order 2,3,0,1 -> requester 3 granted in the draining cycle
    chk("bp_release_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("bp_done_cnt",  32'(done_cnt),  32'd1);
    chk("bp_new_id",    32'(rsp_id),    32'd3);
    chk("bp_new_data",  32'(rsp_data),  32'h11);   // ctl3=000 -> d00
    chk("bp_rr_ptr",    32'(dbg_rr_ptr), 32'd0);
    tick();
    settle();
    chk("drain_done_cnt",  32'(done_cnt),  32'd2);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Round-robin fairness: all requesting, consumer always ready
    // ctl: req0=000->d00, req1=001->d01, req2=100->d10, req3=011->d11
    req_ctl = 12'b011_100_001_000;
    exp_id_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      e_id   = exp_id_q.pop_front();
      e_data = exp_q.pop_front();
      settle();
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << e_id));
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rr_rsp_id",    32'(rsp_id),    32'(e_id));
      chk("rr_rsp_data",  32'(rsp_data),  32'(e_data));
    end
    req_valid = 4'h0;
    tick();
    settle();
    chk("rr_done_cnt", 32'(done_cnt),   32'd7);
    chk("rr_idle",     32'(rsp_valid),  32'd0);
    chk("rr_ptr_end",  32'(dbg_rr_ptr), 32'd1);

    // Skip idle requesters: set rr_ptr=2 via a grant to 1, then only req0
    req_valid = 4'b0010;
    tick();
    settle();
    chk("skip_ptr_setup", 32'(dbg_rr_ptr), 32'd2);
    req_valid = 4'b0001;
    settle();
    chk("skip_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("skip_rsp_id",  32'(rsp_id),     32'd0);
    chk("skip_rr_ptr",  32'(dbg_rr_ptr), 32'd1);
    chk("skip_done",    32'(done_cnt),   32'd8);
    tick();
    settle();
    chk("skip_drain_done", 32'(done_cnt), 32'd9);

    // Counter wrap on the CNT_W=4 instance: reach 17 accepted responses
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) tick();
    settle();
    chk("wrap_done16_at16", 32'(done_cnt),  32'd16);
    chk("wrap_done4_at16",  32'(done_cnt4), 32'd0);
    req_valid = 4'h0;
    tick();
    settle();
    chk("wrap_done16_at17", 32'(done_cnt),  32'd17);
    chk("wrap_done4_at17",  32'(done_cnt4), 32'd1);
    chk("wrap_idle",        32'(rsp_valid), 32'd0);

    // Asynchronous reset while a response is pending
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'h0;
    settle();
    chk("rst2_pre_valid", 32'(rsp_valid), 32'd1);
    chk("rst2_pre_data",  32'(rsp_data),  32'h11);
    req_valid = 4'hF;
    #1 CLR = 1'b1;
    #1;
    chk("rst2_rsp_valid",  32'(rsp_valid), 32'd0);
    chk("rst2_rsp_data",   32'(rsp_data),  32'd0);
    chk("rst2_done_cnt",   32'(done_cnt),  32'd0);
    chk("rst2_done_cnt4",  32'(done_cnt4), 32'd0);
    chk("rst2_busy",       32'(busy),      32'd0);
    chk("rst2_req_ready",  32'(req_ready), 32'd0);
    chk("rst2_state",      32'(dbg_state), 32'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
